obstacle_scheduler: RTL and testbench
=====================================

// Module: obstacle_scheduler
// PURPOSE
// Owns the obstacle slot pool consumed by the frame-level game logic (collision) and renderer.
// Spawns top/bottom pillar pairs at fixed frame intervals with an LFSR-chosen gap.
// Scrolls all live pillars left, retires them off-screen and counts passed pairs as score.
// Runs on the same 60Hz frame clock and follows the 2-bit gamemode from game logic.
// PARAMETERS
// NUM_OBS        10   slot count; must be even (pair p = slots 2p top, 2p+1 bottom)
// SCREEN_W       640  spawn right edge (x)
// OBS_WIDTH      40   pillar width
// SPEED          2    pixels scrolled per run frame
// SPAWN_INTERVAL 90   run frames between spawn attempts (>=1)
// GAP            160  vertical opening height
// UPPER_BOUND    20   playfield top y
// LOWER_BOUND    460  playfield bottom y
// MIN_PILLAR     40   minimum pillar height above gap
// PLAYER_X_LEFT  160  score line x
// LFSR_SEED      8'hA5  LFSR value after reset (nonzero)
// PORTS
// clk              in   1             frame clock
// rst_n            in   1             async active-low reset
// gamemode         in   2             00 idle/reset, 01 run, 10 pause, 11 crash
// obstacle_x_left  out  [NUM_OBS][10] slot left x
// obstacle_x_right out  [NUM_OBS][10] slot right x
// obstacle_y_up    out  [NUM_OBS][9]  slot top y
// obstacle_y_down  out  [NUM_OBS][9]  slot bottom y
// score            out  10            pairs passed, saturates at 1023
// spawn_miss       out  1             one-cycle pulse: spawn due, no free pair
// BEHAVIOUR
// Clock and reset: one clock clk; rst_n asynchronous, active-low.
// Reset: all slots inactive, all coordinate outputs 0, score 0, spawn_miss 0, frame counter 0, LFSR = LFSR_SEED.
// Outputs registered; slot state is visible the cycle after the frame that updates it.
// Inactive slot outputs all-zero coordinates (zero area; never collides).
// LFSR: 8-bit Galois, poly x^8+x^6+x^5+x^4+1; advances every cycle in every mode; reseeded only by rst_n.
// gamemode 00: all slots cleared to inactive/zero; counter 0; score 0; spawn_miss 0.
// gamemode 10 or 11: slots, counter and score held; spawn_miss 0.
// gamemode 01, per frame, all from registered state:
// - Scroll: each active slot x_right -= SPEED; x_left = (x_left<SPEED) ? 0 : x_left-SPEED.
// - Retire: an active slot with old x_right <= SPEED goes inactive and is zeroed (no scroll).
// - Score: per pair, +1 when the top slot's old x_right >= PLAYER_X_LEFT and new x_right < PLAYER_X_LEFT.
//   Sum all pairs; saturating add at 1023.
// - Counter: counter == SPAWN_INTERVAL-1 -> spawn attempt, counter <= 0; else counter+1.
// - Spawn: pick the lowest-index pair whose two slots are both inactive in the registered state.
//   A pair retired this frame is not reusable until the next frame.
// - Gap: off = lfsr[6:0] (0..127); gap_top = UPPER_BOUND+MIN_PILLAR+off.
// - Spawned top slot: x = SCREEN_W-OBS_WIDTH..SCREEN_W; y = UPPER_BOUND..gap_top.
// - Spawned bottom slot: same x; y = gap_top+GAP..LOWER_BOUND.
// - Spawned slots are not scrolled in their spawn frame.
// - No free pair: no slot changes; spawn_miss = 1 for that cycle; counter still wraps to 0.
// Mode change 01->10->01 resumes exactly where it stopped; rst_n mid-run acts immediately.
// TESTING
// Reset: rst_n=0 -> all coords 0, score 0, spawn_miss 0; release, gamemode=00 20 frames -> still all 0.
// First spawn: gamemode=01 -> after 90 frames slots 0/1 at x 600..640;
//   y_up0=20, y_down0=60+off, y_up1=y_down0+160, y_down1=460; off = LFSR[6:0] that frame.
// Scroll/pause: 10 run frames after spawn -> x_left 580, x_right 620.
//   gamemode=10 for 5 frames -> unchanged; back to 01 -> 578/618.
// Score/retire: run until x_right falls 160->158 -> score 0->1.
//   At x_right=2 -> next frame slots zeroed and pair 0 reusable.
// Pool full: SPAWN_INTERVAL=1, SPEED=1 -> pairs 0..4 fill on frames 1..5.
//   Frame 6 -> spawn_miss=1 for one cycle, no slot changes.
// Crash/clear: gamemode=11 mid-run -> all outputs frozen; then 00 -> all slots 0, score 0.
//   Then 01 -> first spawn after 90 frames.

Source files
------------

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: frame-rate pillar pool. Spawns LFSR-gapped top/bottom pairs, scrolls them
//   left, retires off-screen slots and scores pairs whose top pillar crosses the player line.
// Latency: one frame. Every output is a register, updated on the frame that changes it.
// Backpressure: none. A spawn that is due when no pair is free is dropped and flagged on spawn_miss.
// Ports:
//   clk, rst_n                     frame clock, async active-low reset
//   gamemode                       00 clear, 01 run, 10 pause (hold), 11 crash (hold)
//   obstacle_x_left/x_right        per-slot horizontal extent, zero while the slot is inactive
//   obstacle_y_up/y_down           per-slot vertical extent, zero while the slot is inactive
//   score                          pairs passed, saturating at 1023
//   spawn_miss                     one-frame pulse: spawn was due but every pair was busy
module obstacle_scheduler #(
  parameter int         NUM_OBS        = 10,
  parameter int         SCREEN_W       = 640,
  parameter int         OBS_WIDTH      = 40,
  parameter int         SPEED          = 2,
  parameter int         SPAWN_INTERVAL = 90,
  parameter int         GAP            = 160,
  parameter int         UPPER_BOUND    = 20,
  parameter int         LOWER_BOUND    = 460,
  parameter int         MIN_PILLAR     = 40,
  parameter int         PLAYER_X_LEFT  = 160,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               gamemode,
  output logic [NUM_OBS-1:0][9:0]  obstacle_x_left,
  output logic [NUM_OBS-1:0][9:0]  obstacle_x_right,
  output logic [NUM_OBS-1:0][8:0]  obstacle_y_up,
  output logic [NUM_OBS-1:0][8:0]  obstacle_y_down,
  output logic [9:0]               score,
  output logic                     spawn_miss
);

  localparam int         NUM_PAIRS = NUM_OBS / 2;
  localparam int         CNT_W     = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
  localparam logic [9:0] SPD       = 10'(SPEED);
  localparam logic [9:0] SPAWN_XL  = 10'(SCREEN_W - OBS_WIDTH);
  localparam logic [9:0] SPAWN_XR  = 10'(SCREEN_W);
  localparam logic [9:0] SCORE_X   = 10'(PLAYER_X_LEFT);
  localparam logic [8:0] Y_TOP     = 9'(UPPER_BOUND);
  localparam logic [8:0] Y_BOT     = 9'(LOWER_BOUND);
  localparam logic [8:0] GAP_H     = 9'(GAP);
  localparam logic [8:0] GAP_BASE  = 9'(UPPER_BOUND + MIN_PILLAR);

  logic [NUM_OBS-1:0]       r_act, w_act_n;
  logic [NUM_OBS-1:0][9:0]  r_xl, r_xr, w_xl_n, w_xr_n;
  logic [NUM_OBS-1:0][8:0]  r_yu, r_yd, w_yu_n, w_yd_n;
  logic [CNT_W-1:0]         r_cnt, w_cnt_n;
  logic [9:0]               r_score, w_score_n;
  logic                     r_miss, w_miss_n;
  logic [7:0]               r_lfsr, w_lfsr_n;
  logic                     w_due;
  logic [8:0]               w_gap_top;
  logic [9:0]               w_passed;
  logic [10:0]              w_sum;
  logic                     w_found;

  assign w_due     = (r_cnt == CNT_W'(SPAWN_INTERVAL - 1));
  assign w_gap_top = GAP_BASE + {2'b00, r_lfsr[6:0]};
  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1; free-runs in every mode.
  assign w_lfsr_n  = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);

  always_comb begin
    w_act_n   = r_act;
    w_xl_n    = r_xl;
    w_xr_n    = r_xr;
    w_yu_n    = r_yu;
    w_yd_n    = r_yd;
    w_cnt_n   = r_cnt;
    w_score_n = r_score;
    w_miss_n  = 1'b0;
    w_passed  = '0;
    w_sum     = '0;
    w_found   = 1'b0;
    case (gamemode)
      2'b00: begin
        w_act_n   = '0;
        w_xl_n    = '0;
        w_xr_n    = '0;
        w_yu_n    = '0;
        w_yd_n    = '0;
        w_cnt_n   = '0;
        w_score_n = '0;
      end
      2'b01: begin
        // Scroll or retire every live slot.
        for (int i = 0; i < NUM_OBS; i++) begin
          if (r_act[i]) begin
            if (r_xr[i] <= SPD) begin
              w_act_n[i] = 1'b0;
              w_xl_n[i]  = '0;
              w_xr_n[i]  = '0;
              w_yu_n[i]  = '0;
              w_yd_n[i]  = '0;
            end else begin
              w_xr_n[i] = r_xr[i] - SPD;
              w_xl_n[i] = (r_xl[i] < SPD) ? 10'd0 : r_xl[i] - SPD;
            end
          end
        end
        // A pair scores once, on the frame its top pillar's right edge crosses the line.
        for (int p = 0; p < NUM_PAIRS; p++) begin
          if (r_act[2*p] && (r_xr[2*p] >= SCORE_X) && (w_xr_n[2*p] < SCORE_X))
            w_passed = w_passed + 10'd1;
        end
        w_sum     = {1'b0, r_score} + {1'b0, w_passed};
        w_score_n = w_sum[10] ? 10'h3FF : w_sum[9:0];
        if (w_due) begin
          w_cnt_n = '0;
          // Freeness comes from registered state, so a pair retired this frame waits a frame.
          for (int p = 0; p < NUM_PAIRS; p++) begin
            if (!w_found && !r_act[2*p] && !r_act[2*p+1]) begin
              w_found          = 1'b1;
              w_act_n[2*p]     = 1'b1;
              w_xl_n[2*p]      = SPAWN_XL;
              w_xr_n[2*p]      = SPAWN_XR;
              w_yu_n[2*p]      = Y_TOP;
              w_yd_n[2*p]      = w_gap_top;
              w_act_n[2*p+1]   = 1'b1;
              w_xl_n[2*p+1]    = SPAWN_XL;
              w_xr_n[2*p+1]    = SPAWN_XR;
              w_yu_n[2*p+1]    = w_gap_top + GAP_H;
              w_yd_n[2*p+1]    = Y_BOT;
            end
          end
          w_miss_n = !w_found;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: begin
        // Pause and crash freeze the playfield; defaults already hold everything.
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act   <= '0;
      r_xl    <= '0;
      r_xr    <= '0;
      r_yu    <= '0;
      r_yd    <= '0;
      r_cnt   <= '0;
      r_score <= '0;
      r_miss  <= 1'b0;
      r_lfsr  <= LFSR_SEED;
    end else begin
      r_act   <= w_act_n;
      r_xl    <= w_xl_n;
      r_xr    <= w_xr_n;
      r_yu    <= w_yu_n;
      r_yd    <= w_yd_n;
      r_cnt   <= w_cnt_n;
      r_score <= w_score_n;
      r_miss  <= w_miss_n;
      r_lfsr  <= w_lfsr_n;
    end
  end

  assign obstacle_x_left  = r_xl;
  assign obstacle_x_right = r_xr;
  assign obstacle_y_up    = r_yu;
  assign obstacle_y_down  = r_yd;
  assign score            = r_score;
  assign spawn_miss       = r_miss;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: two schedulers (default timing, and a fast one that fills its pool)
//   share one gamemode/reset; a reference model predicts each frame's outputs into per-DUT
//   queues that a monitor drains and compares shortly after every clock edge.
module tb_obstacle_scheduler;
  localparam int N = 10;

  typedef struct packed {
    logic [N-1:0][9:0] xl;
    logic [N-1:0][9:0] xr;
    logic [N-1:0][8:0] yu;
    logic [N-1:0][8:0] yd;
    logic [9:0]        score;
    logic              miss;
  } snap_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        gamemode;
  logic [N-1:0][9:0] xl0, xr0, xl1, xr1;
  logic [N-1:0][8:0] yu0, yd0, yu1, yd1;
  logic [9:0]        sc0, sc1;
  logic              miss0, miss1;

  int checks = 0;
  int errors = 0;

  snap_t q0[$];
  snap_t q1[$];

  // Reference state per instance (0 = default, 1 = interval 1 / speed 1).
  int m_act[2][N];
  int m_xl[2][N];
  int m_xr[2][N];
  int m_yu[2][N];
  int m_yd[2][N];
  int m_cnt[2];
  int m_score[2];
  int m_miss[2];
  int m_lfsr[2];

  always #5 clk = ~clk;

  obstacle_scheduler u_dut0 (
    .clk(clk), .rst_n(rst_n), .gamemode(gamemode),
    .obstacle_x_left(xl0), .obstacle_x_right(xr0),
    .obstacle_y_up(yu0), .obstacle_y_down(yd0),
    .score(sc0), .spawn_miss(miss0)
  );

  obstacle_scheduler #(.SPAWN_INTERVAL(1), .SPEED(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .gamemode(gamemode),
    .obstacle_x_left(xl1), .obstacle_x_right(xr1),
    .obstacle_y_up(yu1), .obstacle_y_down(yd1),
    .score(sc1), .spawn_miss(miss1)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_slot(input int k, input int i);
    m_act[k][i] = 0; m_xl[k][i] = 0; m_xr[k][i] = 0; m_yu[k][i] = 0; m_yd[k][i] = 0;
  endtask

  task automatic model_reset(input int k);
    for (int i = 0; i < N; i++) clear_slot(k, i);
    m_cnt[k] = 0; m_score[k] = 0; m_miss[k] = 0; m_lfsr[k] = 'hA5;
  endtask

  // One frame of game rules applied to the state as it stood at the start of the frame.
  task automatic model_step(input int k, input logic [1:0] gm);
    int oa[N];
    int oxr[N];
    int sp, iv, passed, off, gtop;
    bit found;
    sp = (k == 1) ? 1 : 2;
    iv = (k == 1) ? 1 : 90;
    for (int i = 0; i < N; i++) begin
      oa[i]  = m_act[k][i];
      oxr[i] = m_xr[k][i];
    end
    off  = m_lfsr[k] % 128;
    gtop = 20 + 40 + off;
    if (gm == 2'b00) begin
      for (int i = 0; i < N; i++) clear_slot(k, i);
      m_cnt[k] = 0; m_score[k] = 0; m_miss[k] = 0;
    end else if (gm == 2'b01) begin
      m_miss[k] = 0;
      for (int i = 0; i < N; i++) begin
        if (oa[i] != 0) begin
          if (oxr[i] <= sp) clear_slot(k, i);
          else begin
            m_xr[k][i] = oxr[i] - sp;
            m_xl[k][i] = (m_xl[k][i] < sp) ? 0 : m_xl[k][i] - sp;
          end
        end
      end
      passed = 0;
      for (int p = 0; p < N / 2; p++)
        if (oa[2*p] != 0 && oxr[2*p] >= 160 && m_xr[k][2*p] < 160) passed++;
      m_score[k] = (m_score[k] + passed > 1023) ? 1023 : m_score[k] + passed;
      if (m_cnt[k] == iv - 1) begin
        m_cnt[k] = 0;
        found = 0;
        for (int p = 0; p < N / 2; p++) begin
          if (!found && oa[2*p] == 0 && oa[2*p+1] == 0) begin
            found = 1;
            m_act[k][2*p]   = 1; m_xl[k][2*p]   = 600; m_xr[k][2*p]   = 640;
            m_yu[k][2*p]    = 20; m_yd[k][2*p]  = gtop;
            m_act[k][2*p+1] = 1; m_xl[k][2*p+1] = 600; m_xr[k][2*p+1] = 640;
            m_yu[k][2*p+1]  = gtop + 160; m_yd[k][2*p+1] = 460;
          end
        end
        if (!found) m_miss[k] = 1;
      end else begin
        m_cnt[k]++;
      end
    end else begin
      m_miss[k] = 0;
    end
    m_lfsr[k] = (m_lfsr[k] >> 1) ^ (((m_lfsr[k] & 1) != 0) ? 'hB8 : 0);
  endtask

  function automatic snap_t model_snap(input int k);
    snap_t s;
    for (int i = 0; i < N; i++) begin
      s.xl[i] = 10'(m_xl[k][i]);
      s.xr[i] = 10'(m_xr[k][i]);
      s.yu[i] = 9'(m_yu[k][i]);
      s.yd[i] = 9'(m_yd[k][i]);
    end
    s.score = 10'(m_score[k]);
    s.miss  = (m_miss[k] != 0);
    return s;
  endfunction

  function automatic snap_t dut_snap(input int k);
    snap_t s;
    if (k == 0) begin
      s.xl = xl0; s.xr = xr0; s.yu = yu0; s.yd = yd0; s.score = sc0; s.miss = miss0;
    end else begin
      s.xl = xl1; s.xr = xr1; s.yu = yu1; s.yd = yd1; s.score = sc1; s.miss = miss1;
    end
    return s;
  endfunction

  task automatic compare(input int k, input snap_t a, input snap_t e);
    chk($sformatf("u%0d x_left", k),  128'(a.xl),    128'(e.xl));
    chk($sformatf("u%0d x_right", k), 128'(a.xr),    128'(e.xr));
    chk($sformatf("u%0d y_up", k),    128'(a.yu),    128'(e.yu));
    chk($sformatf("u%0d y_down", k),  128'(a.yd),    128'(e.yd));
    chk($sformatf("u%0d score", k),   128'(a.score), 128'(e.score));
    chk($sformatf("u%0d miss", k),    128'(a.miss),  128'(e.miss));
  endtask

  // Inputs change on the falling edge; the expected post-edge state is queued at the same time.
  task automatic step(input logic [1:0] gm, input logic rn);
    @(negedge clk);
    gamemode = gm;
    rst_n    = rn;
    for (int k = 0; k < 2; k++) begin
      if (!rn) model_reset(k);
      else     model_step(k, gm);
    end
    q0.push_back(model_snap(0));
    q1.push_back(model_snap(1));
  endtask

  task automatic random_run(input int frames);
    for (int i = 0; i < frames; i++)
      step(($urandom_range(0, 7) == 0) ? 2'b10 : 2'b01, 1'b1);
  endtask

  // Monitor: compares whatever the DUTs present just after each rising edge.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        compare(0, dut_snap(0), e);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        compare(1, dut_snap(1), e);
      end
    end
  end

  initial begin
    gamemode = 2'b00;
    rst_n    = 1'b0;
    model_reset(0);
    model_reset(1);
    q0.push_back(model_snap(0));
    q1.push_back(model_snap(1));

    repeat (3) step(2'b00, 1'b0);
    repeat (20) step(2'b00, 1'b1);

    // First spawn lands on the 90th run frame.
    repeat (90) step(2'b01, 1'b1);
    @(posedge clk); #3;
    chk("first spawn x_left0",  128'(xl0[0]), 128'(600));
    chk("first spawn x_right0", 128'(xr0[0]), 128'(640));
    chk("first spawn y_up0",    128'(yu0[0]), 128'(20));
    chk("first spawn y_down1",  128'(yd0[1]), 128'(460));

    repeat (10) step(2'b01, 1'b1);
    @(posedge clk); #3;
    chk("scroll x_left0", 128'(xl0[0]), 128'(580));
    repeat (5) step(2'b10, 1'b1);
    @(posedge clk); #3;
    chk("pause x_right0", 128'(xr0[0]), 128'(620));
    step(2'b01, 1'b1);
    @(posedge clk); #3;
    chk("resume x_left0",  128'(xl0[0]), 128'(578));
    chk("resume x_right0", 128'(xr0[0]), 128'(618));

    random_run(400);
    repeat (8) step(2'b11, 1'b1);
    repeat (4) step(2'b00, 1'b1);
    random_run(700);

    // Reset mid-run must clear outputs before any further clock edge.
    step(2'b01, 1'b0);
    #1;
    chk("async reset x_left",  128'(xl0), 128'(0));
    chk("async reset x_left1", 128'(xl1), 128'(0));
    chk("async reset score",   128'(sc0), 128'(0));
    repeat (2) step(2'b01, 1'b0);
    random_run(200);
    repeat (3) step(2'b00, 1'b1);

    @(posedge clk); #3;
    chk("queue drained", 128'(q0.size() + q1.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
